// File: rtl/csr_file_if.sv
// Zicsr instruction port and trap-controller port of the machine-mode CSR file.
interface csr_file_if #(
  parameter int unsigned XLEN = 32
);
  logic            csr_access;
  logic            csr_write_enable;
  logic [11:0]     csr_address;
  logic [XLEN-1:0] csr_write_data;
  logic [XLEN-1:0] csr_read_data;
  logic            csr_illegal;
  logic            trap_write_enable;
  logic [11:0]     trap_address;
  logic [XLEN-1:0] trap_write_data;
  logic [XLEN-1:0] trap_read_data;

  modport master (
    output csr_access, csr_write_enable, csr_address, csr_write_data,
    output trap_write_enable, trap_address, trap_write_data,
    input  csr_read_data, csr_illegal, trap_read_data
  );

  modport slave (
    input  csr_access, csr_write_enable, csr_address, csr_write_data,
    input  trap_write_enable, trap_address, trap_write_data,
    output csr_read_data, csr_illegal, trap_read_data
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR register file for the RV32I core: trap port, Zicsr port, counters.
// Define ZICNTR_EN to implement the 64-bit mcycle/minstret counters and their shadows.
module csr_file #(
  parameter int unsigned XLEN        = 32,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_enable,
  input  logic       instret_inc,
  csr_file_if.slave  bus
);

  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic [XLEN-3:0] mtvec_base;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-3:0] mepc_base;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;
  logic            illegal;
  logic            instr_we;
  logic            trap_we;

`ifdef ZICNTR_EN
  logic [63:0] mcycle;
  logic [63:0] minstret;
`else
  logic unused_instret;
  assign unused_instret = instret_inc;
`endif

  function automatic logic implemented(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
      12'hF11, 12'hF12, 12'hF13, 12'hF14: return 1'b1;
`ifdef ZICNTR_EN
      12'hB00, 12'hB80, 12'hB02, 12'hB82,
      12'hC00, 12'hC80, 12'hC02, 12'hC82: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] read_csr(input logic [11:0] a);
    logic [XLEN-1:0] r;
    r = '0;
    case (a)
      12'h300: r = XLEN'({19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0});
      12'h301: r = MISA_VALUE;
      12'h305: r = {mtvec_base, 2'b00};
      12'h340: r = mscratch;
      12'h341: r = {mepc_base, 2'b00};
      12'h342: r = mcause;
      12'h343: r = mtval;
`ifdef ZICNTR_EN
      12'hB00, 12'hC00: r = mcycle[31:0];
      12'hB80, 12'hC80: r = mcycle[63:32];
      12'hB02, 12'hC02: r = minstret[31:0];
      12'hB82, 12'hC82: r = minstret[63:32];
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  // Trap writes take the whole address; an instruction write to the same address is dropped.
  function automatic logic wr_hit(input logic [11:0] a);
    return (trap_we && bus.trap_address == a) || (instr_we && bus.csr_address == a);
  endfunction

  function automatic logic [XLEN-1:0] wr_val(input logic [11:0] a);
    return (trap_we && bus.trap_address == a) ? bus.trap_write_data : bus.csr_write_data;
  endfunction

  always_comb begin
    illegal = 1'b0;
    if (bus.csr_access) begin
      illegal = !implemented(bus.csr_address) ||
                (bus.csr_write_enable &&
                 (bus.csr_address[11:10] == 2'b11 || bus.csr_address == 12'h301));
    end
  end

  always_comb begin
    trap_we  = clk_enable && bus.trap_write_enable;
    instr_we = clk_enable && bus.csr_access && bus.csr_write_enable && !illegal &&
               !(bus.trap_write_enable && bus.trap_address == bus.csr_address);
  end

  // No write-to-read bypass: reads always reflect the registered state.
  always_comb begin
    bus.csr_read_data  = read_csr(bus.csr_address);
    bus.trap_read_data = read_csr(bus.trap_address);
    bus.csr_illegal    = illegal;
  end

  // Writes to read-only or unimplemented addresses never match a register below.
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mtvec_base   <= MTVEC_RESET[31:2];
      mscratch     <= '0;
      mepc_base    <= '0;
      mcause       <= '0;
      mtval        <= '0;
    end else begin
      if (wr_hit(12'h300)) begin
        mstatus_mie  <= |(wr_val(12'h300) & XLEN'(32'h0000_0008));
        mstatus_mpie <= |(wr_val(12'h300) & XLEN'(32'h0000_0080));
      end
      if (wr_hit(12'h305)) mtvec_base <= (XLEN-2)'(wr_val(12'h305) >> 2);
      if (wr_hit(12'h340)) mscratch   <= wr_val(12'h340);
      if (wr_hit(12'h341)) mepc_base  <= (XLEN-2)'(wr_val(12'h341) >> 2);
      if (wr_hit(12'h342)) mcause     <= wr_val(12'h342);
      if (wr_hit(12'h343)) mtval      <= wr_val(12'h343);
    end
  end

`ifdef ZICNTR_EN
  // Low-half write suppresses the increment; high-half write drops the low-half carry.
  function automatic logic [63:0] cnt_next(input logic [63:0] cur, input logic inc,
                                           input logic [11:0] lo_a, input logic [11:0] hi_a);
    logic [32:0] lo_sum;
    logic [31:0] lo;
    logic [31:0] hi;
    lo_sum = {1'b0, cur[31:0]} + 33'(inc);
    lo     = wr_hit(lo_a) ? wr_val(lo_a) : lo_sum[31:0];
    hi     = wr_hit(hi_a) ? wr_val(hi_a) : cur[63:32] + 32'(lo_sum[32] && !wr_hit(lo_a));
    return {hi, lo};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle   <= '0;
      minstret <= '0;
    end else if (clk_enable) begin
      mcycle   <= cnt_next(mcycle, 1'b1, 12'hB00, 12'hB80);
      minstret <= cnt_next(minstret, instret_inc, 12'hB02, 12'hB82);
    end
  end
`endif

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file for the RV32I core.
- Sits directly downstream of the trap controller:
  - It consumes the controller's trap write port (enable, address, data).
  - It returns `trap_read_data`, which feeds back as the controller's `csr_read_data` when mtvec/mepc is read.
- A second port serves Zicsr instructions from the pipeline.
- It also holds the 64-bit cycle/instret counters.

Parameters:
- XLEN, 32, data width; only 32 is supported.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec; bits [1:0] are forced to 0.
- MISA_VALUE, 32'h4000_0100, read-only misa contents (RV32I).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- clk_enable  in  1  global stall gate; no state changes while low
- csr_access  in  1  Zicsr instruction is accessing `csr_address` this cycle
- csr_write_enable  in  1  instruction write request
- csr_address  in  12  instruction read/write address
- csr_write_data  in  XLEN  final value to write (RW/RS/RC already merged upstream)
- csr_read_data  out  XLEN  combinational read of `csr_address`
- csr_illegal  out  1  illegal CSR access indication
- trap_write_enable  in  1  trap-controller write strobe
- trap_address  in  12  trap-controller read/write address
- trap_write_data  in  XLEN  trap-controller write data
- trap_read_data  out  XLEN  combinational read of `trap_address`
- instret_inc  in  1  one instruction retired this cycle

Behaviour:
- All state updates occur at posedge clk, and only when clk_enable=1.
- Reset (sync, priority over clk_enable):
  - mstatus=32'h0000_1800 (MPP=11).
  - mtvec=MTVEC_RESET with bits [1:0] cleared.
  - mscratch, mepc, mcause, mtval=0.
  - mcycle and minstret (64-bit) = 0.
  - The read outputs therefore show these values from the first cycle after reset.
- Implemented map:
  - 0x300 mstatus: writable mask 32'h0000_0088 (MIE, MPIE); MPP reads 11; other bits read 0.
  - 0x301 misa: read-only, returns MISA_VALUE.
  - 0x305 mtvec: direct mode only; bits [1:0] read 0.
  - 0x340 mscratch.
  - 0x341 mepc: bits [1:0] read 0.
  - 0x342 mcause.
  - 0x343 mtval.
  - 0xB00/0xB80 mcycle/mcycleh.
  - 0xB02/0xB82 minstret/minstreth.
  - 0xC00/0xC80/0xC02/0xC82: read-only shadows of the counters.
  - 0xF11–0xF14: read 0.
  - Any other address is unimplemented and reads 0.
- Reads: both ports are purely combinational from current state. There is no write-to-read bypass: a read in the same cycle as a write returns the old value.
- csr_illegal (combinational): asserted when csr_access=1 and either
  - the address is unimplemented, or
  - csr_write_enable=1 and (csr_address[11:10]==2'b11 or address==0x301).
  - An illegal write does not modify state.
- Trap port:
  - Writes to unimplemented or read-only addresses are silently dropped; it never raises csr_illegal.
  - The trap port has no privilege check.
- Simultaneous writes:
  - Same address on both ports: the trap write wins and the instruction write is discarded.
  - Different addresses: both commit in the same cycle.
- Counters (each cycle with clk_enable=1, absent writes):
  - mcycle += 1.
  - minstret += instret_inc.
  - Carry propagates from bit 31 into the high half; the counter wraps from 2^64-1 to 0.
- Counter write vs increment:
  - Write to the low half: low = write data, high unchanged, no increment that cycle.
  - Write to the high half: high = write data; the low half increments normally and any carry out of it is dropped.
- clk_enable=0: counters hold and writes are ignored; reads stay valid.

Optional Feature:
- Macro: ZICNTR_EN.
- Defined: the counters and their shadow addresses are implemented as described above.
- Undefined:
  - No counter registers exist.
  - Addresses 0xB00/0xB80/0xB02/0xB82/0xC00/0xC80/0xC02/0xC82 are unimplemented: they read 0 and raise csr_illegal on access.
  - instret_inc is ignored.

Test Plan:
- Reset, then release with clk_enable=1:
  - trap_address=0x305 → trap_read_data=MTVEC_RESET & ~3.
  - csr_address=0x300 → 32'h0000_1800.
- Trap write 0x341 data 32'h0000_1237, next cycle → mepc reads 32'h0000_1234. Trap write 0x342 data 11 → mcause reads 11.
- Same cycle: trap write 0x341=32'hA0 and instruction write 0x341=32'hB0 → mepc=32'hA0. csr_illegal=0.
- csr_access=1, write to 0xC00 → csr_illegal=1 and counter unaffected. Access to 0x7FF → csr_illegal=1, read 0.
- Write mcycle=32'hFFFF_FFFE, then 3 enabled cycles → mcycle=32'h0000_0001, mcycleh=1. Hold clk_enable=0 for 5 cycles → values unchanged.
- With instret_inc=1 for 4 cycles and 0 for 2, from reset → minstret=4. Without ZICNTR_EN → a read of 0xB02 gives 0 with csr_illegal=1.
